uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serialiser between P_NUM_REQ byte sources.
- Round-robin arbitration with per-requester valid/ready handshake.
- Sequences the transmitter's valid/ready handshake: one byte in flight, no double capture.
- Sits between on-chip producers (console, debug, status reporter) and the single UART TX pin driver.

Parameters:
- P_NUM_REQ, 4, number of requesters (2..8).
- P_DATA_BITS, 8, byte width; matches transmitter data width.
- P_ID_W, $clog2(P_NUM_REQ), grant-id width (derived localparam, not overridable).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  P_NUM_REQ  per-requester byte valid.
- i_req_data  in  P_NUM_REQ*P_DATA_BITS  packed bytes; requester k at [k*P_DATA_BITS +: P_DATA_BITS].
- i_req_last  in  P_NUM_REQ  last byte of a packet (used only with lock feature).
- o_req_ready  out  P_NUM_REQ  one-hot accept strobe.
- o_tx_data  out  P_DATA_BITS  byte to transmitter, registered.
- o_tx_data_valid  out  1  single-cycle issue pulse to transmitter.
- i_tx_ready  in  1  transmitter idle flag.
- o_grant_id  out  P_ID_W  index of requester owning the current byte.
- o_busy  out  1  high whenever state != ARB.

Behaviour:
- Reset values: o_req_ready=0, o_tx_data=0, o_tx_data_valid=0, o_grant_id=0, o_busy=0, state=ARB, rr pointer=P_NUM_REQ-1, so requester 0 wins first.
- States: ARB, ISSUE, WAIT_LO, WAIT_HI.
- ARB:
  - If any i_req_valid, select the first valid requester searching from pointer+1 with wrap.
  - o_req_ready is combinational: one-hot of the winner, asserted only in ARB.
  - Same edge: capture i_req_data slice into o_tx_data, set o_grant_id, pointer <= winner, go to ISSUE.
  - No valid: stay in ARB, o_req_ready=0.
- ISSUE:
  - If i_tx_ready=1: o_tx_data_valid=1 for exactly this cycle, go to WAIT_LO.
  - Else: hold in ISSUE.
- WAIT_LO: wait for i_tx_ready=0, confirming the transmitter captured the byte; then go to WAIT_HI.
- WAIT_HI: wait for i_tx_ready=1, then go to ARB.
  - Rationale: the transmitter's ready lags its return to idle by one cycle, so a byte is never issued while it reloads.
- Latency: requester accept to issue pulse is 1 cycle minimum (ISSUE immediately after ARB with i_tx_ready=1).
- Throughput: at most one byte per transmitter frame plus 2 cycles overhead.
- o_tx_data is stable from the accept edge until the next accept.
- Requesters must hold data while valid and not ready.
  - A requester dropping valid before its grant is legal; it simply loses the round.
- Simultaneous requests: round-robin order strictly, no starvation; worst-case wait is P_NUM_REQ-1 bytes.
- Pointer wrap: after requester P_NUM_REQ-1 is served, the search starts at 0.
- i_tx_ready stuck low: the block waits forever in ISSUE or WAIT_HI; no timeout.
- Reset mid-frame: immediate return to reset values; any in-flight byte is abandoned. The transmitter shares the same reset.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined:
  - If the accepted byte has i_req_last=0, the next ARB grants only that requester, waiting for its valid and ignoring others, until a byte with i_req_last=1 is accepted.
  - Keeps packets contiguous on the line.
  - The pointer advances only when the lock is released.
  - Lock state resets to unlocked.
- Undefined: i_req_last is ignored; arbitration is per byte.

Decomposition:
- Package uart_pkg:
  - state enum (ARB/ISSUE/WAIT_LO/WAIT_HI);
  - default P_DATA_BITS;
  - parity-type constants shared with the transmitter.
- Sub-module rr_arbiter:
  - combinational round-robin selector;
  - inputs: request vector, pointer;
  - outputs: one-hot grant, index, any.
  - Reusable for future RX-side or I2C masters.

Test Plan:
- Single requester 1 sends 0xA5, stub TX with ready low 3 cycles after capture then high:
  - o_req_ready[1] pulses once;
  - o_tx_data=0xA5 with one valid pulse;
  - o_grant_id=1.
- All 4 valid continuously, 8 bytes each: issue order 0,1,2,3,0,1,2,3…; each requester receives exactly 8 ready strobes.
- i_tx_ready held low 20 cycles when entering ISSUE: no valid pulse until ready rises, then exactly one pulse.
- Only requester 3 valid, then requester 0 raises valid during WAIT_HI: next grant 0 (wrap from pointer 3).
- Reset asserted in WAIT_LO: all outputs return to reset values next edge; after release, requester 0 wins first.
- With UART_TX_ARB_LOCK_EN, requester 2 sends 3 bytes (last on third) while 0 and 1 are valid: order 2,2,2,0,1; without the macro: 2,0,1,2,…

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Contents:
//   arb_state_e       - TX arbiter sequencing states
//   DEFAULT_DATA_BITS - default byte width shared by arbiter and transmitter
//   parity_e          - parity selection shared with the transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        StArb    = 2'd0,
        StIssue  = 2'd1,
        StWaitLo = 2'd2,
        StWaitHi = 2'd3
    } arb_state_e;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ParityNone = 2'd0,
        ParityEven = 2'd1,
        ParityOdd  = 2'd2
    } parity_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Searches the request vector starting one above the pointer, wrapping around,
// and returns the first set request.
// Ports:
//   req   - request vector
//   ptr   - index of the most recently served requester
//   grant - one-hot grant (all zero when no request)
//   idx   - binary index of the granted requester
//   any   - at least one request present
module rr_arbiter #(
    parameter int unsigned P_NUM_REQ = 4,
    localparam int unsigned P_ID_W = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req,
    input  logic [P_ID_W-1:0]    ptr,
    output logic [P_NUM_REQ-1:0] grant,
    output logic [P_ID_W-1:0]    idx,
    output logic                 any
);

    logic [P_ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // Offsets 1..P_NUM_REQ: the pointed-to requester is considered last.
        for (int i = 1; i <= int'(P_NUM_REQ); i++) begin
            cand = P_ID_W'((int'(ptr) + i) % int'(P_NUM_REQ));
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between P_NUM_REQ byte sources.
// Round-robin selection, one byte in flight; the transmitter handshake is
// tracked through its ready flag (drop = byte captured, rise = idle again).
// Optional feature macro: UART_TX_ARB_LOCK_EN keeps packets (runs of bytes
// ending with i_req_last=1) contiguous by locking the grant to one requester.
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_req_valid      - per-requester byte valid
//   i_req_data       - packed bytes, requester k at [k*P_DATA_BITS +: P_DATA_BITS]
//   i_req_last       - last byte of a packet (lock feature only)
//   o_req_ready      - one-hot accept strobe
//   o_tx_data        - byte to transmitter, registered at accept
//   o_tx_data_valid  - single-cycle issue pulse to transmitter
//   i_tx_ready       - transmitter idle flag
//   o_grant_id       - requester owning the current byte
//   o_busy           - high whenever not arbitrating
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_DATA_BITS = DEFAULT_DATA_BITS,
    localparam int unsigned P_ID_W     = $clog2(P_NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [P_NUM_REQ-1:0]           i_req_valid,
    input  logic [P_NUM_REQ*P_DATA_BITS-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]           i_req_last,
    output logic [P_NUM_REQ-1:0]           o_req_ready,
    output logic [P_DATA_BITS-1:0]         o_tx_data,
    output logic                           o_tx_data_valid,
    input  logic                           i_tx_ready,
    output logic [P_ID_W-1:0]              o_grant_id,
    output logic                           o_busy
);

    arb_state_e              state_q;
    logic [P_ID_W-1:0]       ptr_q;
    logic [P_DATA_BITS-1:0]  tx_data_q;
    logic [P_ID_W-1:0]       grant_id_q;

    logic [P_NUM_REQ-1:0]    eligible;
    logic [P_NUM_REQ-1:0]    win_grant;
    logic [P_ID_W-1:0]       win_idx;
    logic                    win_any;
    logic [P_DATA_BITS-1:0]  req_bytes [P_NUM_REQ];

    for (genvar k = 0; k < int'(P_NUM_REQ); k++) begin : g_unpack
        assign req_bytes[k] = i_req_data[k*P_DATA_BITS +: P_DATA_BITS];
    end

`ifdef UART_TX_ARB_LOCK_EN
    logic              lock_q;
    logic [P_ID_W-1:0] lock_id_q;

    // While locked only the owning requester may win.
    assign eligible = lock_q ? (i_req_valid & (P_NUM_REQ'(1) << lock_id_q)) : i_req_valid;
`else
    logic unused_last;

    assign unused_last = ^i_req_last;
    assign eligible    = i_req_valid;
`endif

    rr_arbiter #(
        .P_NUM_REQ (P_NUM_REQ)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Accept strobe is combinational so the requester sees it in the same
    // cycle the byte is captured; gated by reset so it reads zero in reset.
    assign o_req_ready     = (i_rst_n && state_q == StArb && win_any) ? win_grant : '0;
    // Pulse only while the transmitter is idle; the next cycle we are in
    // StWaitLo, so this can never repeat for the same byte.
    assign o_tx_data_valid = (state_q == StIssue) && i_tx_ready;
    assign o_busy          = (state_q != StArb);
    assign o_tx_data       = tx_data_q;
    assign o_grant_id      = grant_id_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StArb;
            ptr_q      <= P_ID_W'(P_NUM_REQ - 1);
            tx_data_q  <= '0;
            grant_id_q <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StArb: begin
                    if (win_any) begin
                        tx_data_q  <= req_bytes[win_idx];
                        grant_id_q <= win_idx;
                        state_q    <= StIssue;
`ifdef UART_TX_ARB_LOCK_EN
                        // Pointer moves only when the packet ends, so the
                        // round-robin order resumes from the packet owner.
                        if (i_req_last[win_idx]) begin
                            lock_q <= 1'b0;
                            ptr_q  <= win_idx;
                        end else begin
                            lock_q    <= 1'b1;
                            lock_id_q <= win_idx;
                        end
`else
                        ptr_q <= win_idx;
`endif
                    end
                end
                StIssue: begin
                    if (i_tx_ready) begin
                        state_q <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    // Ready dropping confirms the transmitter took the byte.
                    if (!i_tx_ready) begin
                        state_q <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (i_tx_ready) begin
                        state_q <= StArb;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a stub transmitter whose
// ready drops for FRAME cycles after each capture, a per-cycle reference
// model of the arbitration/handshake rules, and directed scenario checks.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int FRAME = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_data      (req_data),
        .i_req_last      (req_last),
        .o_req_ready     (req_ready),
        .o_tx_data       (tx_data),
        .o_tx_data_valid (tx_valid),
        .i_tx_ready      (tx_ready),
        .o_grant_id      (grant_id),
        .o_busy          (busy)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] q_data [N][$];
    bit         q_last [N][$];
    int         strobe_cnt [N];
    int         log_id [$];
    logic [7:0] log_data [$];
    bit         hold_low = 1'b0;
    int         cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input bit l);
        q_data[k].push_back(d);
        q_last[k].push_back(l);
    endtask

    task automatic update_inputs();
        for (int k = 0; k < N; k++) begin
            if (q_data[k].size() > 0) begin
                req_valid[k]          = 1'b1;
                req_data[k*DW +: DW]  = q_data[k][0];
                req_last[k]           = q_last[k][0];
            end else begin
                req_valid[k]          = 1'b0;
                req_data[k*DW +: DW]  = '0;
                req_last[k]           = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Environment: byte sources pop on accept, stub transmitter captures on
    // the issue pulse. Both act on values sampled mid-cycle.
    logic [N-1:0] env_hs;
    logic         env_cap;
    logic [7:0]   env_cap_data;
    int           env_cap_id;

    always begin
        @(negedge clk);
        env_hs       = req_ready & req_valid;
        env_cap      = tx_valid;
        env_cap_data = tx_data;
        env_cap_id   = int'(grant_id);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                q_data[k].delete();
                q_last[k].delete();
            end
            tx_ready = 1'b1;
            cnt      = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (env_hs[k]) begin
                    void'(q_data[k].pop_front());
                    void'(q_last[k].pop_front());
                    strobe_cnt[k]++;
                end
            end
            if (env_cap === 1'b1) begin
                log_id.push_back(env_cap_id);
                log_data.push_back(env_cap_data);
                tx_ready = 1'b0;
                cnt      = FRAME - 1;
            end else if (!tx_ready) begin
                if (cnt > 0) cnt--;
                else if (!hold_low) tx_ready = 1'b1;
            end else if (hold_low) begin
                tx_ready = 1'b0;
            end
        end
        update_inputs();
    end

    // Reference model. Phases of one byte's life:
    //   0 free, 1 holding a byte not yet offered, 2 offered awaiting ready
    //   drop, 3 awaiting transmitter idle.
    int         m_phase = 0;
    int         m_ptr = N - 1;
    bit         m_lock = 1'b0;
    int         m_lock_id = 0;
    logic [7:0] m_data = '0;
    int         m_id = 0;
    logic [N-1:0] m_elig;
    logic [N-1:0] exp_ready;
    int           w;

    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        for (int i = 1; i <= N; i++) begin
            if (elig[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    always begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_busy", busy, 0);
            m_phase = 0; m_ptr = N - 1; m_lock = 1'b0; m_lock_id = 0; m_data = '0; m_id = 0;
        end else begin
            m_elig = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
            if (m_lock) m_elig = req_valid & (4'b0001 << m_lock_id);
`endif
            w = pick(m_elig, m_ptr);
            exp_ready = (m_phase == 0 && w >= 0) ? (4'b0001 << w) : 4'b0000;
            chk("req_ready", req_ready, exp_ready);
            chk("tx_valid", tx_valid, (m_phase == 1 && tx_ready) ? 1 : 0);
            chk("busy", busy, (m_phase != 0) ? 1 : 0);
            chk("tx_data", tx_data, m_data);
            chk("grant_id", grant_id, m_id);
            case (m_phase)
                0: if (w >= 0) begin
                    m_data  = req_data[w*DW +: DW];
                    m_id    = w;
                    m_phase = 1;
`ifdef UART_TX_ARB_LOCK_EN
                    if (req_last[w]) begin m_lock = 1'b0; m_ptr = w; end
                    else begin m_lock = 1'b1; m_lock_id = w; end
`else
                    m_ptr = w;
`endif
                end
                1: if (tx_ready) m_phase = 2;
                2: if (!tx_ready) m_phase = 3;
                3: if (tx_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic wait_issues(input int n, input string name);
        int b = 0;
        while (log_id.size() < n && b < 5000) begin
            tick();
            b++;
        end
        if (log_id.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d issues expected %0d", name, log_id.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        bit idle = 1'b0;
        while (!idle && b < 2000) begin
            idle = !busy && tx_ready;
            for (int k = 0; k < N; k++) if (q_data[k].size() > 0) idle = 1'b0;
            if (!idle) begin tick(); b++; end
        end
        if (!idle) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: got busy=%0b expected busy=0", name, busy);
        end
    endtask

    task automatic clear_strobes();
        for (int k = 0; k < N; k++) strobe_cnt[k] = 0;
    endtask

    int base;
    int exp6 [5];

    initial begin
        req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
        clear_strobes();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single requester 1 sends 0xA5.
        clear_strobes();
        base = log_id.size();
        push(1, 8'hA5, 1'b1); update_inputs();
        wait_issues(base + 1, "single");
        wait_idle("single");
        chk("single_strobe1", strobe_cnt[1], 1);
        chk("single_strobe_others", strobe_cnt[0] + strobe_cnt[2] + strobe_cnt[3], 0);
        chk("single_pulses", log_id.size() - base, 1);
        chk("single_data", log_data[base], 8'hA5);
        chk("single_id", log_id[base], 1);

        // All four continuously valid, 8 bytes each; pointer is 1 so 2 leads.
        clear_strobes();
        base = log_id.size();
        for (int j = 0; j < 8; j++) for (int k = 0; k < N; k++) push(k, 8'(k * 16 + j), 1'b1);
        update_inputs();
        wait_issues(base + 32, "rr");
        wait_idle("rr");
        for (int k = 0; k < N; k++) chk("rr_strobes", strobe_cnt[k], 8);
        for (int i = 0; i < 32; i++) begin
            chk("rr_order", log_id[base + i], (2 + i) % 4);
            chk("rr_data", log_data[base + i], ((2 + i) % 4) * 16 + (i + 2) / 4 - ((2 + i) % 4 < 2 ? 1 : 0));
        end

        // Transmitter ready held low for 20 cycles while a byte waits.
        hold_low = 1'b1;
        tick(); tick();
        base = log_id.size();
        push(0, 8'h5A, 1'b1); update_inputs();
        repeat (20) tick();
        chk("hold_no_pulse", log_id.size() - base, 0);
        chk("hold_busy", busy, 1);
        hold_low = 1'b0;
        wait_issues(base + 1, "hold");
        wait_idle("hold");
        chk("hold_one_pulse", log_id.size() - base, 1);
        chk("hold_data", log_data[base], 8'h5A);

        // Requester 3 alone, then 0 and 2 arrive during the idle wait.
        base = log_id.size();
        push(3, 8'h3C, 1'b1); update_inputs();
        wait_issues(base + 1, "wrap");
        tick();
        chk("wrap_busy", busy, 1);
        push(0, 8'h0C, 1'b1); push(2, 8'h2C, 1'b1); update_inputs();
        wait_issues(base + 3, "wrap");
        wait_idle("wrap");
        chk("wrap_first", log_id[base + 1], 0);
        chk("wrap_second", log_id[base + 2], 2);

        // Reset while waiting for the transmitter to capture.
        base = log_id.size();
        push(1, 8'h77, 1'b1); update_inputs();
        wait_issues(base + 1, "rstmid");
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_data", tx_data, 0);
        chk("rstmid_id", grant_id, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        base = log_id.size();
        for (int k = 0; k < N; k++) push(k, 8'(8'h80 + k), 1'b1);
        update_inputs();
        wait_issues(base + 4, "rstmid");
        wait_idle("rstmid");
        chk("rstmid_first", log_id[base], 0);

        // Packet of three from requester 2 with 0 and 1 competing.
        clear_strobes();
        base = log_id.size();
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1); update_inputs();
        for (int b = 0; b < 200 && strobe_cnt[2] == 0; b++) tick();
        push(0, 8'h0A, 1'b1); push(1, 8'h1A, 1'b1); update_inputs();
        wait_issues(base + 5, "pkt");
        wait_idle("pkt");
`ifdef UART_TX_ARB_LOCK_EN
        exp6 = '{2, 2, 2, 0, 1};
`else
        exp6 = '{2, 0, 1, 2, 2};
`endif
        for (int i = 0; i < 5; i++) chk("pkt_order", log_id[base + i], exp6[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
